temporal_interval: RTL and testbench



---
 rtl/temporal_interval.sv | 148 ++++++++++++++
 tb/tb_temporal_interval.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/temporal_interval.sv
// temporal_interval: flexible temporal relation between two points of an
// interactive score. A start pulse opens the interval; it closes on an
// interactive trigger inside [DMIN, DMAX] or is forced closed at DMAX.
// end_pulse launches the next temporal object downstream.
module temporal_interval #(
    parameter int CNT_W    = 32,
    parameter int TICK_DIV = 100000,
    parameter int DMIN     = 2,
    parameter int DMAX     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             trigger,
    input  logic             abort,
    output logic             active,
    output logic             in_window,
    output logic             end_pulse,
    output logic             end_forced,
    output logic             early_trig,
    output logic             aborted,
    output logic [CNT_W-1:0] elapsed
);

    // Prescaler needs at least one bit even when TICK_DIV == 1.
    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DMIN_C   = CNT_W'(DMIN);
    localparam logic [CNT_W-1:0] DMAX_C   = CNT_W'(DMAX);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_MIN   = 2'd1,
        WAIT_EVENT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic             end_pulse_q, end_pulse_d;
    logic             end_forced_q, end_forced_d;
    logic             early_trig_q, early_trig_d;
    logic             aborted_q, aborted_d;

    logic             tick;
    logic [PRE_W-1:0] pre_inc;
    logic [CNT_W-1:0] elapsed_inc;

    // Time base: the prescaler wraps every TICK_DIV cycles and advances
    // elapsed by one unit, saturating at DMAX.
    always_comb begin
        tick        = (pre_q == PRE_LAST);
        pre_inc     = tick ? '0 : pre_q + 1'b1;
        elapsed_inc = (tick && (elapsed_q != DMAX_C)) ? elapsed_q + 1'b1 : elapsed_q;
    end

    // Next-state and registered-output decode; the counters freeze on the
    // edge that leaves the interval so elapsed reports the closing time.
    always_comb begin
        state_d      = state_q;
        pre_d        = pre_q;
        elapsed_d    = elapsed_q;
        end_pulse_d  = 1'b0;
        end_forced_d = end_forced_q;
        early_trig_d = 1'b0;
        aborted_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // start together with abort is a no-op.
                if (start && !abort) begin
                    pre_d        = '0;
                    elapsed_d    = '0;
                    end_forced_d = 1'b0;
                    state_d      = (DMIN == 0) ? WAIT_EVENT : WAIT_MIN;
                end
            end

            WAIT_MIN: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    pre_d        = pre_inc;
                    elapsed_d    = elapsed_inc;
                    // Too-early trigger is reported and dropped, not latched.
                    early_trig_d = trigger;
                    if (elapsed_inc == DMIN_C) begin
                        state_d = WAIT_EVENT;
                    end
                end
            end

            WAIT_EVENT: begin
                // abort beats trigger, trigger beats the DMAX timeout.
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (trigger) begin
                    state_d      = IDLE;
                    end_pulse_d  = 1'b1;
                    end_forced_d = 1'b0;
                end else if (elapsed_q == DMAX_C) begin
                    state_d      = IDLE;
                    end_pulse_d  = 1'b1;
                    end_forced_d = 1'b1;
                end else begin
                    pre_d     = pre_inc;
                    elapsed_d = elapsed_inc;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, time base and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pre_q        <= '0;
            elapsed_q    <= '0;
            end_pulse_q  <= 1'b0;
            end_forced_q <= 1'b0;
            early_trig_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            elapsed_q    <= elapsed_d;
            end_pulse_q  <= end_pulse_d;
            end_forced_q <= end_forced_d;
            early_trig_q <= early_trig_d;
            aborted_q    <= aborted_d;
        end
    end

    assign active     = (state_q != IDLE);
    assign in_window  = (state_q == WAIT_EVENT);
    assign end_pulse  = end_pulse_q;
    assign end_forced = end_forced_q;
    assign early_trig = early_trig_q;
    assign aborted    = aborted_q;
    assign elapsed    = elapsed_q;

endmodule

// File: tb/tb_temporal_interval.sv
// Testbench for temporal_interval: four parameterisations side by side,
// end_pulse events checked against a scoreboard of expected ends.
module tb_temporal_interval;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start, trigger, abort;
    logic [3:0]  active, in_window, end_pulse, end_forced, early_trig, aborted;
    logic [31:0] elapsed [4];

    always #5 clk = ~clk;

    // Instance 0: TD=1 DMIN=2 DMAX=5, 1: TD=4 2/5, 2: TD=1 0/0, 3: TD=2 1/3
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            localparam int TDV   = (gi == 1) ? 4 : (gi == 3) ? 2 : 1;
            localparam int DMINV = (gi == 2) ? 0 : (gi == 3) ? 1 : 2;
            localparam int DMAXV = (gi == 2) ? 0 : (gi == 3) ? 3 : 5;
            temporal_interval #(
                .CNT_W(32), .TICK_DIV(TDV), .DMIN(DMINV), .DMAX(DMAXV)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .start     (start[gi]),
                .trigger   (trigger[gi]),
                .abort     (abort[gi]),
                .active    (active[gi]),
                .in_window (in_window[gi]),
                .end_pulse (end_pulse[gi]),
                .end_forced(end_forced[gi]),
                .early_trig(early_trig[gi]),
                .aborted   (aborted[gi]),
                .elapsed   (elapsed[gi])
            );
        end
    endgenerate

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          inst;
        int          at;
        logic        forced;
        logic [31:0] el;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   end_cnt[4] = '{default: 0};
    int   ab_cnt[4]  = '{default: 0};
    int   et_cnt[4]  = '{default: 0};

    // Monitor: every end_pulse pops one expected end and is compared to it.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (aborted[i] === 1'b1) begin
                ab_cnt[i]++;
                $display("txn inst %0d aborted at cycle %0d", i, cyc);
            end
            if (early_trig[i] === 1'b1) begin
                et_cnt[i]++;
                $display("txn inst %0d early trigger at cycle %0d", i, cyc);
            end
            if (end_pulse[i] === 1'b1) begin
                end_cnt[i]++;
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                end else begin
                    mon_e.inst = -1; mon_e.at = -1; mon_e.forced = 1'bx; mon_e.el = 'x;
                end
                $display("txn inst %0d end at cycle %0d forced %0d elapsed %0d (exp cycle %0d)",
                         i, cyc, end_forced[i], elapsed[i], mon_e.at);
                check_val("end_inst", i, mon_e.inst);
                check_val("end_cycle", cyc, mon_e.at);
                check_val("end_forced", 32'(end_forced[i]), 32'(mon_e.forced));
                check_val("end_elapsed", elapsed[i], mon_e.el);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic pulse_start(input int i, output int e);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        e = cyc;
    endtask

    task automatic push_exp(input int i, input int at, input logic f, input logic [31:0] el);
        exp_t x;
        x.inst = i; x.at = at; x.forced = f; x.el = el;
        sb_q.push_back(x);
    endtask

    int e;
    int w;

    initial begin
        rst = 1'b1; start = '0; trigger = '0; abort = '0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            check_val("rst_flags", 32'({active[i], in_window[i], end_pulse[i],
                                        end_forced[i], early_trig[i], aborted[i]}), 0);
            check_val("rst_elapsed", elapsed[i], 0);
        end
        rst = 1'b0;
        tick();

        // Forced end, TD=1 DMIN=2 DMAX=5
        pulse_start(0, e);
        push_exp(0, e + 6, 1'b1, 5);
        check_val("a_active", 32'(active[0]), 1);
        check_val("a_win_e0", 32'(in_window[0]), 0);
        run_to(e + 1);
        check_val("a_win_e1", 32'(in_window[0]), 0);
        run_to(e + 2);
        check_val("a_win_e2", 32'(in_window[0]), 1);
        check_val("a_el_e2", elapsed[0], 2);
        run_to(e + 6);
        check_val("a_end", 32'(end_pulse[0]), 1);
        check_val("a_forced", 32'(end_forced[0]), 1);
        run_to(e + 8);
        check_val("a_idle", 32'(active[0]), 0);
        check_val("a_el_hold", elapsed[0], 5);
        check_val("a_forced_hold", 32'(end_forced[0]), 1);

        // Reset mid-interval at elapsed=3
        pulse_start(0, e);
        run_to(e + 3);
        check_val("r_el3", elapsed[0], 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("r_flags", 32'({active[0], in_window[0], end_pulse[0],
                                  end_forced[0], early_trig[0], aborted[0]}), 0);
        check_val("r_elapsed", elapsed[0], 0);

        // Restart; trigger on the cycle elapsed==DMAX wins over the timeout
        pulse_start(0, e);
        push_exp(0, e + 6, 1'b0, 5);
        run_to(e + 5);
        check_val("s_el5", elapsed[0], 5);
        trigger[0] = 1'b1;
        tick();
        trigger[0] = 1'b0;
        check_val("s_end", 32'(end_pulse[0]), 1);
        check_val("s_forced", 32'(end_forced[0]), 0);
        tick();
        check_val("s_single", 32'(end_pulse[0]), 0);
        check_val("s_idle", 32'(active[0]), 0);

        // abort with trigger in WAIT_EVENT
        pulse_start(0, e);
        run_to(e + 3);
        check_val("ab_win", 32'(in_window[0]), 1);
        abort[0] = 1'b1; trigger[0] = 1'b1;
        tick();
        abort[0] = 1'b0; trigger[0] = 1'b0;
        check_val("ab_aborted", 32'(aborted[0]), 1);
        check_val("ab_no_end", 32'(end_pulse[0]), 0);
        check_val("ab_idle", 32'(active[0]), 0);
        tick();
        check_val("ab_pulse_len", 32'(aborted[0]), 0);

        // abort in WAIT_MIN
        pulse_start(0, e);
        run_to(e + 1);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check_val("am_aborted", 32'(aborted[0]), 1);
        check_val("am_idle", 32'(active[0]), 0);

        // start together with abort in IDLE does nothing
        tick();
        start[0] = 1'b1; abort[0] = 1'b1;
        tick();
        start[0] = 1'b0; abort[0] = 1'b0;
        check_val("sa_idle", 32'(active[0]), 0);
        check_val("sa_no_abort", 32'(aborted[0]), 0);

        // TD=4 DMIN=2 DMAX=5: early trigger then interactive end
        pulse_start(1, e);
        run_to(e + 5);
        check_val("b_el1", elapsed[1], 1);
        trigger[1] = 1'b1;
        tick();
        trigger[1] = 1'b0;
        check_val("b_early", 32'(early_trig[1]), 1);
        check_val("b_open", 32'(active[1]), 1);
        check_val("b_no_end", 32'(end_pulse[1]), 0);
        run_to(e + 7);
        check_val("b_win_e7", 32'(in_window[1]), 0);
        run_to(e + 8);
        check_val("b_win_e8", 32'(in_window[1]), 1);
        run_to(e + 12);
        check_val("b_el3", elapsed[1], 3);
        push_exp(1, e + 13, 1'b0, 3);
        trigger[1] = 1'b1;
        tick();
        trigger[1] = 1'b0;
        check_val("b_end", 32'(end_pulse[1]), 1);
        check_val("b_forced", 32'(end_forced[1]), 0);
        run_to(e + 20);
        check_val("b_el_hold", elapsed[1], 3);
        check_val("b_idle", 32'(active[1]), 0);

        // DMIN=DMAX=0: window immediately, forced end next edge, start ignored
        pulse_start(2, e);
        check_val("c_win", 32'(in_window[2]), 1);
        check_val("c_el0", elapsed[2], 0);
        push_exp(2, e + 1, 1'b1, 0);
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        check_val("c_end", 32'(end_pulse[2]), 1);
        check_val("c_forced", 32'(end_forced[2]), 1);
        tick();
        check_val("c_ignored", 32'(active[2]), 0);

        // Back-to-back: TD=2 DMIN=1 DMAX=3, 100 intervals
        for (int k = 0; k < 100; k++) begin
            pulse_start(3, e);
            push_exp(3, e + 7, 1'b1, 3);
            w = 0;
            while (end_pulse[3] !== 1'b1 && w < 20) begin
                tick();
                w++;
            end
            if (end_pulse[3] !== 1'b1) begin
                check_val("d_end_timeout", 32'(end_pulse[3]), 1);
                break;
            end
        end
        repeat (3) tick();

        check_val("d_end_count", end_cnt[3], 100);
        check_val("d_no_abort", ab_cnt[3], 0);
        check_val("d_no_early", et_cnt[3], 0);
        check_val("a_end_count", end_cnt[0], 2);
        check_val("a_abort_count", ab_cnt[0], 2);
        check_val("b_early_count", et_cnt[1], 1);
        check_val("c_end_count", end_cnt[2], 1);
        check_val("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
